// File: rtl/edge_detector_zc_if.sv
// Sample/edge bus for edge_detector_zc: the sample stream in, the second
// difference and edge measurements out.
interface edge_detector_zc_if #(
    parameter int DATA_WIDTH  = 20,
    parameter int COUNT_WIDTH = 16
);
    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic signed [DATA_WIDTH+1:0]  d_value;
    logic                          d_valid;
    logic                          pulse;
    logic                          pulse_dir;
    logic [COUNT_WIDTH-1:0]        edge_count;
    logic [COUNT_WIDTH-1:0]        interval;
    logic                          interval_valid;

    modport master (
        output in_valid, in_data,
        input  d_value, d_valid, pulse, pulse_dir,
        input  edge_count, interval, interval_valid
    );

    modport slave (
        input  in_valid, in_data,
        output d_value, d_valid, pulse, pulse_dir,
        output edge_count, interval, interval_valid
    );
endinterface

// File: rtl/edge_detector_zc.sv
// Laplacian zero-crossing edge detector: second difference over a 3-sample
// window, dead-band classification, direction filter, holdoff and interval timing.
module edge_detector_zc #(
    parameter int DATA_WIDTH  = 20,
    parameter int THRESH      = 4,
    parameter int HOLDOFF     = 0,
    parameter int EDGE_MODE   = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    edge_detector_zc_if.slave bus
);

    localparam int DW2 = DATA_WIDTH + 2;
    localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic signed [DW2-1:0] THR_POS = DW2'(THRESH);
    localparam logic signed [DW2-1:0] THR_NEG = -THR_POS;

    localparam logic [1:0] SIGN_NONE = 2'd0;
    localparam logic [1:0] SIGN_POS  = 2'd1;
    localparam logic [1:0] SIGN_NEG  = 2'd2;

    logic [DATA_WIDTH-1:0]  w0_q, w0_d;
    logic [DATA_WIDTH-1:0]  w1_q, w1_d;
    logic [1:0]             fill_q, fill_d;
    logic [1:0]             sign_q, sign_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [COUNT_WIDTH-1:0] smp_q, smp_d;
    logic signed [DW2-1:0]  d_value_q, d_value_d;
    logic                   d_valid_q, d_valid_d;
    logic                   pulse_q, pulse_d;
    logic                   pulse_dir_q, pulse_dir_d;
    logic [COUNT_WIDTH-1:0] edge_count_q, edge_count_d;
    logic [COUNT_WIDTH-1:0] interval_q, interval_d;
    logic                   interval_valid_q, interval_valid_d;

    logic signed [DW2-1:0]  d_calc;
    logic                   d_ok, is_pos, is_neg, rising, falling, dir_ok, emit;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Zero-extended operands keep the result exact: |d| <= 2^(DATA_WIDTH+1)-2.
    assign d_calc  = {2'b00, bus.in_data} - ({2'b00, w0_q} << 1) + {2'b00, w1_q};
    assign d_ok    = (fill_q >= 2'd2);
    assign is_pos  = d_ok && (d_calc >= THR_POS);
    assign is_neg  = d_ok && (d_calc <= THR_NEG);
    assign rising  = (sign_q == SIGN_NEG) && is_pos;
    assign falling = (sign_q == SIGN_POS) && is_neg;
    assign dir_ok  = (rising && (EDGE_MODE != 2)) || (falling && (EDGE_MODE != 1));
    assign emit    = bus.in_valid && dir_ok && (hold_q == '0);

    always_comb begin
        // NOTE: every next-state value starts from its hold value so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        w0_d             = w0_q;
        w1_d             = w1_q;
        fill_d           = fill_q;
        sign_d           = sign_q;
        hold_d           = hold_q;
        smp_d            = smp_q;
        d_value_d        = d_value_q;
        d_valid_d        = d_valid_q;
        pulse_d          = 1'b0;
        pulse_dir_d      = pulse_dir_q;
        edge_count_d     = edge_count_q;
        interval_d       = interval_q;
        interval_valid_d = interval_valid_q;

        if (bus.in_valid) begin
            w1_d = w0_q;
            w0_d = bus.in_data;
            if (fill_q != 2'd3) fill_d = fill_q + 2'd1;

            if (d_ok) begin
                d_value_d = d_calc;
                d_valid_d = 1'b1;
            end

            // Dead-band samples leave the remembered polarity untouched.
            if (is_pos)      sign_d = SIGN_POS;
            else if (is_neg) sign_d = SIGN_NEG;

            if (emit) begin
                pulse_d      = 1'b1;
                pulse_dir_d  = rising;
                edge_count_d = sat_inc(edge_count_q);
                hold_d       = HW'(HOLDOFF);
                if (edge_count_q != '0) begin
                    interval_d       = sat_inc(smp_q);
                    interval_valid_d = 1'b1;
                end
                smp_d = '0;
            end else begin
                if (hold_q != '0) hold_d = hold_q - HW'(1);
                smp_d = sat_inc(smp_q);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q             <= '0;
            w1_q             <= '0;
            fill_q           <= '0;
            sign_q           <= SIGN_NONE;
            hold_q           <= '0;
            smp_q            <= '0;
            d_value_q        <= '0;
            d_valid_q        <= 1'b0;
            pulse_q          <= 1'b0;
            pulse_dir_q      <= 1'b0;
            edge_count_q     <= '0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
        end else begin
            w0_q             <= w0_d;
            w1_q             <= w1_d;
            fill_q           <= fill_d;
            sign_q           <= sign_d;
            hold_q           <= hold_d;
            smp_q            <= smp_d;
            d_value_q        <= d_value_d;
            d_valid_q        <= d_valid_d;
            pulse_q          <= pulse_d;
            pulse_dir_q      <= pulse_dir_d;
            edge_count_q     <= edge_count_d;
            interval_q       <= interval_d;
            interval_valid_q <= interval_valid_d;
        end
    end

    assign bus.d_value        = d_value_q;
    assign bus.d_valid        = d_valid_q;
    assign bus.pulse          = pulse_q;
    assign bus.pulse_dir      = pulse_dir_q;
    assign bus.edge_count     = edge_count_q;
    assign bus.interval       = interval_q;
    assign bus.interval_valid = interval_valid_q;

endmodule
